// File: rtl/mips_md_pkg.sv
// Shared types for the multiply/divide unit: operation codes and controller states.
package mips_md_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } md_state_t;

  function automatic logic op_is_signed(md_op_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/md_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor,
// keep the difference when it does not borrow.
module md_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dbit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             qbit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  assign shifted = {rem_in, dbit};
  assign trial   = shifted - {1'b0, divisor};

  // rem_in < divisor keeps shifted below 2*divisor, so trial's top bit is exactly the borrow.
  assign qbit    = ~trial[WIDTH];
  assign rem_out = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// One iteration per cycle on unsigned magnitudes, sign correction in a final FIX cycle.
module mult_div_unit
  import mips_md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  md_op_t           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  md_state_t          state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;      // multiply: {partial product, multiplier}; divide: {remainder, dividend/quotient}
  logic [WIDTH-1:0]   opb;      // multiplicand or divisor magnitude
  logic               div_mode;
  logic               neg_q;
  logic               neg_r;
  logic               div_zero;

  logic               sgn;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   rem_next;
  logic               qbit;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign busy  = (state != IDLE);

  assign sgn   = op_is_signed(op);
  assign a_mag = (sgn && a[WIDTH-1]) ? -a : a;
  assign b_mag = (sgn && b[WIDTH-1]) ? -b : b;

  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);

  md_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in  (acc[2*WIDTH-1:WIDTH]),
    .dbit    (acc[WIDTH-1]),
    .divisor (opb),
    .rem_out (rem_next),
    .qbit    (qbit)
  );

  // Divide by zero naturally leaves the dividend magnitude as remainder; only the quotient is forced.
  assign prod    = neg_q ? -acc : acc;
  assign quo_fix = div_zero ? '1 : (neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
  assign rem_fix = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  // NOTE: every register here uses non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      opb      <= '0;
      div_mode <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              MD_MTHI: hi <= a;
              MD_MTLO: lo <= a;
              MD_MULT, MD_MULTU: begin
                acc      <= {{WIDTH{1'b0}}, b_mag};
                opb      <= a_mag;
                div_mode <= 1'b0;
                neg_q    <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_r    <= 1'b0;
                div_zero <= 1'b0;
                cnt      <= '0;
                state    <= CALC;
              end
              MD_DIV, MD_DIVU: begin
                acc      <= {{WIDTH{1'b0}}, a_mag};
                opb      <= b_mag;
                div_mode <= 1'b1;
                neg_q    <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_r    <= sgn & a[WIDTH-1];
                div_zero <= (b == '0);
                cnt      <= '0;
                state    <= CALC;
              end
              default: ;
            endcase
          end
        end
        CALC: begin
          acc <= div_mode ? {rem_next, acc[WIDTH-2:0], qbit}
                          : {mul_sum, acc[WIDTH-1:1]};
          if (cnt == LAST) state <= FIX;
          else             cnt   <= cnt + 1'b1;
        end
        FIX: begin
          if (div_mode) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            {hi, lo} <= prod;
          end
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus randomized
// operations compared against an arithmetic reference model of HI/LO.
module tb_mult_div_unit;
  import mips_md_pkg::*;

  localparam int LAT = 33;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  md_op_t      op    = MD_MULT;
  logic [31:0] a     = '0;
  logic [31:0] b     = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t_start = 0;
  int last_issue = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: architectural effect of one accepted operation on HI/LO.
  function automatic void ref_exec(input md_op_t o, input logic [31:0] x, input logic [31:0] y);
    longint      sp, sa, sb;
    logic [63:0] up;
    case (o)
      MD_MULT: begin
        sp = longint'($signed(x)) * longint'($signed(y));
        {m_hi, m_lo} = sp;
      end
      MD_MULTU: begin
        up = {32'd0, x} * {32'd0, y};
        {m_hi, m_lo} = up;
      end
      MD_DIV: begin
        if (y == 32'd0) begin
          m_hi = x;
          m_lo = 32'hFFFF_FFFF;
        end else begin
          sa = longint'($signed(x));
          sb = longint'($signed(y));
          m_lo = 32'(sa / sb);
          m_hi = 32'(sa % sb);
        end
      end
      MD_DIVU: begin
        if (y == 32'd0) begin
          m_hi = x;
          m_lo = 32'hFFFF_FFFF;
        end else begin
          m_lo = x / y;
          m_hi = x % y;
        end
      end
      MD_MTHI: m_hi = x;
      MD_MTLO: m_lo = x;
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Present one request for exactly one rising edge, then scramble the inputs.
  task automatic issue(input md_op_t o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1;
    last_issue = cyc;
    start = 1'b0;
    op = md_op_t'(3'($urandom));
    a = $urandom;
    b = $urandom;
  endtask

  task automatic wait_done(input string name);
    while (done !== 1'b1 && (cyc - t_start) < LAT + 8) begin
      @(posedge clk);
      #1;
    end
    total++;
    if (done !== 1'b1 || (cyc - t_start) != LAT) begin
      bad++;
      $display("FAIL %s latency: got %0d cycles (done=%b), want %0d", name, cyc - t_start, done, LAT);
    end
  endtask

  task automatic check_result(input string name);
    total++;
    if (hi !== m_hi) begin
      bad++;
      $display("FAIL %s hi: got %h, want %h", name, hi, m_hi);
    end
    total++;
    if (lo !== m_lo) begin
      bad++;
      $display("FAIL %s lo: got %h, want %h", name, lo, m_lo);
    end
  endtask

  task automatic run_md(input md_op_t o, input logic [31:0] x, input logic [31:0] y, input string name);
    issue(o, x, y);
    t_start = last_issue;
    total++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL %s accept: got busy=%b done=%b, want busy=1 done=0", name, busy, done);
    end
    ref_exec(o, x, y);
    wait_done(name);
    check_result(name);
    @(posedge clk);
    #1;
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s pulse: got done=%b busy=%b one cycle later, want 0 0", name, done, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      bad++;
      $display("FAIL reset state: got busy=%b done=%b hi=%h lo=%h, want all zero", busy, done, hi, lo);
    end
  endtask

  task automatic test_directed();
    run_md(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    run_md(MD_MULT,  32'hFFFF_FFFD, 32'd5,         "mult_neg");
    run_md(MD_DIV,   32'hFFFF_FFF9, 32'd2,         "div_neg");
    run_md(MD_DIVU,  32'hFFFF_FFF9, 32'd2,         "divu");
    run_md(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_md(MD_DIVU,  32'd5,         32'd0,         "divu_zero");
    run_md(MD_DIV,   32'hFFFF_FFF0, 32'd0,         "div_zero_neg");
    run_md(MD_MULT,  32'h8000_0000, 32'h8000_0000, "mult_minmin");
  endtask

  task automatic test_move();
    issue(MD_MTLO, 32'h0000_1234, 32'hDEAD_BEEF);
    ref_exec(MD_MTLO, 32'h0000_1234, 32'hDEAD_BEEF);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL mtlo flags: got busy=%b done=%b, want 0 0", busy, done);
    end
    check_result("mtlo");
    issue(MD_MTHI, 32'hCAFE_0001, 32'd0);
    ref_exec(MD_MTHI, 32'hCAFE_0001, 32'd0);
    check_result("mthi");
  endtask

  task automatic test_busy_ignore();
    logic [31:0] old_hi;
    old_hi = hi;
    issue(MD_DIV, 32'd1000, 32'hFFFF_FFFD);
    t_start = last_issue;
    repeat (3) @(posedge clk);
    issue(MD_MTHI, 32'h5555_AAAA, 32'd0);
    total++;
    if (hi !== old_hi) begin
      bad++;
      $display("FAIL mthi_while_busy: got hi=%h, want %h", hi, old_hi);
    end
    issue(MD_DIV, 32'd77, 32'd7);
    ref_exec(MD_DIV, 32'd1000, 32'hFFFF_FFFD);
    wait_done("busy_ignore");
    check_result("busy_ignore");
  endtask

  task automatic test_reset_abort();
    issue(MD_DIV, 32'h7654_3210, 32'd13);
    t_start = last_issue;
    while ((cyc - t_start) < 9) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL abort flags: got busy=%b done=%b, want 0 0", busy, done);
    end
    check_result("abort");
    t_start = cyc;
    while ((cyc - t_start) < LAT + 4 && done !== 1'b1) begin
      @(posedge clk);
      #1;
    end
    total++;
    if (done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      bad++;
      $display("FAIL abort_quiet: got done=%b hi=%h lo=%h, want 0 0 0", done, hi, lo);
    end
    run_md(MD_MULTU, 32'd6, 32'd7, "after_abort");
  endtask

  task automatic test_back_to_back();
    issue(MD_MULT, 32'hFFFF_F000, 32'h0001_0003);
    t_start = last_issue;
    ref_exec(MD_MULT, 32'hFFFF_F000, 32'h0001_0003);
    wait_done("b2b_first");
    check_result("b2b_first");
    issue(MD_DIVU, 32'hFFFF_FFFF, 32'd10);
    t_start = last_issue;
    total++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL b2b accept: got busy=%b done=%b, want 1 0", busy, done);
    end
    ref_exec(MD_DIVU, 32'hFFFF_FFFF, 32'd10);
    wait_done("b2b_second");
    check_result("b2b_second");
  endtask

  task automatic test_random();
    md_op_t      o;
    logic [31:0] x, y;
    for (int i = 0; i < 40; i++) begin
      o = md_op_t'(3'($urandom_range(0, 7)));
      x = pick_operand();
      y = pick_operand();
      if (o == MD_MULT || o == MD_MULTU || o == MD_DIV || o == MD_DIVU) begin
        run_md(o, x, y, "random_md");
      end else begin
        issue(o, x, y);
        ref_exec(o, x, y);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
          bad++;
          $display("FAIL random_move flags op=%0d: got busy=%b done=%b, want 0 0", o, busy, done);
        end
        check_result("random_move");
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_move();
    test_busy_ignore();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers.
- Sits in the execute stage beside the ALU and takes the same rs/rt operand pair.
- Serves MULT, MULTU, DIV, DIVU, MTHI and MTLO. HI/LO are read combinationally for MFHI/MFLO.
- Multi-cycle: the controller stalls on busy.

Parameters:
WIDTH, 32, operand and HI/LO width. Iteration count equals WIDTH.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request strobe, sampled on the rising edge
op  input  3  md_op_t operation code
a  input  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO source)
b  input  WIDTH  rt operand (multiplier / divisor)
busy  output  1  high while an operation is in flight
done  output  1  one-cycle pulse: HI/LO just updated by MULT/DIV
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset is synchronous and active-high, on clk.
  - Reset values: state=IDLE, hi=0, lo=0, busy=0, done=0, iteration counter=0.
  - Reset in any state, including mid-operation, aborts the operation with no partial HI/LO write.
- States: IDLE, CALC, FIX.
  - busy = (state != IDLE), decoded combinationally from state.
- IDLE, start=1 at edge N:
  - MTHI: hi<=a at edge N. MTLO: lo<=a at edge N. State stays IDLE, done stays 0.
  - MULT/MULTU/DIV/DIVU:
    - Latch magnitude operands. Signed ops use |a| and |b|; unsigned ops use a and b raw.
    - Latch the result-sign flags.
    - Clear the counter, go to CALC.
  - Any other op code: no-op.
- CALC, edges N+1..N+WIDTH: one iteration per edge.
  - Multiply: shift-add, 2*WIDTH-bit accumulator.
  - Divide: restoring shift-subtract with a WIDTH+1-bit trial subtraction.
  - At the edge where counter==WIDTH-1, go to FIX.
- FIX, edge N+WIDTH+1:
  - Apply sign correction and write hi/lo.
  - done<=1 and state<=IDLE.
  - done is registered: high exactly one cycle, after edge N+WIDTH+1 (N+33 at default). Self-clears on the next edge.
- Multiply results:
  - {hi,lo} = full 2*WIDTH-bit product.
  - Signed: negate the 64-bit product if the operand signs differ.
- Divide results:
  - lo = quotient, truncated toward zero.
  - hi = remainder, which takes the sign of the dividend.
- Divide by zero, b=0 (signed or unsigned):
  - Normal latency, done pulses.
  - hi = a (original value), lo = all ones.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. No exception.
- Ignored requests:
  - start while busy (CALC or FIX) is ignored, including MTHI/MTLO. No queueing.
  - a, b and op are not required to stay stable after the start edge.
- start in the cycle where done=1 is accepted, since state is IDLE.
- hi and lo change only at an MTHI/MTLO edge, a FIX edge, or reset.

Decomposition:
- Shared package mips_md_pkg holds:
  - typedef enum logic[2:0] md_op_t: MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5 (6,7 unused).
  - typedef enum logic[1:0] md_state_t: IDLE, CALC, FIX.
- One natural sub-module, md_div_step: combinational single restoring-division step.
  - Inputs: partial remainder, dividend bit, divisor.
  - Outputs: next remainder, quotient bit.
  - Instantiated once and iterated by the CALC state.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF, start at edge N -> busy high from N+1. At edge N+33: done=1 for exactly one cycle, hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1 (-15).
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU with the same operands -> lo=0x7FFFFFFC, hi=0x00000001.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=5, b=0 -> hi=5, lo=0xFFFFFFFF, done at N+33.
- MTLO a=0x1234 in IDLE -> lo=0x1234 after the edge, busy and done stay 0.
- MTHI issued during CALC -> hi unchanged. Second DIV start during CALC -> ignored, original result delivered.
- Start DIV, assert reset on the 10th CALC cycle -> next cycle busy=0, done=0, hi=lo=0. A following MULTU 6*7 gives lo=42, hi=0.
